incr_stream_checker: RTL and testbench

//   Receive-side checker for the incrementing-byte stream emitted by the one-state counter generator.

---
 rtl/incr_stream_checker.sv | 112 +++++++++++
 tb/tb_incr_stream_checker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/incr_stream_checker.sv
// Receive-side checker for an incrementing-word stream: hunts, verifies and locks onto a
// +1 (mod 2^WIDTH) sequence, then pulses an error and counts every break while locked.
module incr_stream_checker #(
   parameter int WIDTH         = 8,
   parameter int LOCK_COUNT    = 4,
   parameter int UNLOCK_MISSES = 3,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] __in0,
   input  logic             __in1,
   output logic             __out0,
   output logic             __out1,
   output logic [ERR_W-1:0] __out2
);

   localparam int MW = (LOCK_COUNT    > 1) ? $clog2(LOCK_COUNT + 1)    : 1;
   localparam int NW = (UNLOCK_MISSES > 1) ? $clog2(UNLOCK_MISSES + 1) : 1;

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] expected, expected_n;
   logic [MW-1:0]    match_cnt, match_cnt_n;
   logic [NW-1:0]    miss_cnt, miss_cnt_n;
   logic             lock_q, lock_n;
   logic             err_q, err_n;
   logic [ERR_W-1:0] cnt_q, cnt_n;
   logic             hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HUNT;
         expected  <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         lock_q    <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state     <= state_n;
         expected  <= expected_n;
         match_cnt <= match_cnt_n;
         miss_cnt  <= miss_cnt_n;
         lock_q    <= lock_n;
         err_q     <= err_n;
         cnt_q     <= cnt_n;
      end
   end

   assign hit = (__in0 == expected);

   always_comb begin
      state_n     = state;
      expected_n  = expected;
      match_cnt_n = match_cnt;
      miss_cnt_n  = miss_cnt;
      lock_n      = lock_q;
      err_n       = 1'b0;
      cnt_n       = cnt_q;
      if (__in1) begin
         unique case (state)
            HUNT: begin
               expected_n  = __in0 + WIDTH'(1);
               match_cnt_n = '0;
               state_n     = VERIFY;
            end
            VERIFY: begin
               expected_n = __in0 + WIDTH'(1);
               if (hit) begin
                  // Counter stops one short of LOCK_COUNT; the final match moves to LOCKED instead.
                  if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                     match_cnt_n = '0;
                     miss_cnt_n  = '0;
                     lock_n      = 1'b1;
                     state_n     = LOCKED;
                  end else begin
                     match_cnt_n = match_cnt + MW'(1);
                  end
               end else begin
                  match_cnt_n = '0;
               end
            end
            LOCKED: begin
               if (hit) begin
                  expected_n = __in0 + WIDTH'(1);
                  miss_cnt_n = '0;
               end else begin
                  // Flywheel: keep counting from our own expectation, not the corrupt word.
                  expected_n = expected + WIDTH'(1);
                  err_n      = 1'b1;
                  if (cnt_q != '1) cnt_n = cnt_q + ERR_W'(1);
                  if (miss_cnt == NW'(UNLOCK_MISSES - 1)) begin
                     miss_cnt_n = '0;
                     lock_n     = 1'b0;
                     state_n    = HUNT;
                  end else begin
                     miss_cnt_n = miss_cnt + NW'(1);
                  end
               end
            end
            default: state_n = HUNT;
         endcase
      end
   end

   assign __out0 = lock_q;
   assign __out1 = err_q;
   assign __out2 = cnt_q;

endmodule

// File: tb/tb_incr_stream_checker.sv
// Scoreboard bench for incr_stream_checker: a behavioural model predicts outputs per driven
// cycle, a monitor compares them after the edge, and scenario tasks add targeted checks.
module tb_incr_stream_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in0;
   logic       in1;
   logic       out0;
   logic       out1;
   logic [7:0] out2;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       lock;
      logic       err;
      logic [7:0] cnt;
   } exp_t;

   exp_t sb_q[$];

   // reference model state
   int         m_state = 0;  // 0 hunt, 1 verify, 2 locked
   logic [7:0] m_exp   = '0;
   int         m_match = 0;
   int         m_miss  = 0;
   logic       m_lock  = 1'b0;
   logic       m_err   = 1'b0;
   int         m_cnt   = 0;

   incr_stream_checker #(.WIDTH(8), .LOCK_COUNT(4), .UNLOCK_MISSES(3), .ERR_W(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .__in0  (in0),
      .__in1  (in1),
      .__out0 (out0),
      .__out1 (out1),
      .__out2 (out2)
   );

   always #5 clk = ~clk;

   task automatic model_step(input logic r, input logic v, input logic [7:0] d);
      if (r) begin
         m_state = 0; m_exp = '0; m_match = 0; m_miss = 0;
         m_lock = 1'b0; m_err = 1'b0; m_cnt = 0;
      end else begin
         m_err = 1'b0;
         if (v) begin
            case (m_state)
               0: begin m_exp = d + 8'd1; m_match = 0; m_state = 1; end
               1: begin
                  if (d == m_exp) begin
                     m_match++;
                     if (m_match == 4) begin m_state = 2; m_miss = 0; m_lock = 1'b1; end
                  end else m_match = 0;
                  m_exp = d + 8'd1;
               end
               default: begin
                  if (d == m_exp) begin
                     m_miss = 0; m_exp = d + 8'd1;
                  end else begin
                     m_err = 1'b1;
                     if (m_cnt < 255) m_cnt++;
                     m_miss++;
                     m_exp = m_exp + 8'd1;
                     if (m_miss == 3) begin m_state = 0; m_lock = 1'b0; end
                  end
               end
            endcase
         end
      end
   endtask

   // Drive one cycle, push the model's prediction, return 1 time unit after the sampling edge.
   task automatic drive(input logic r, input logic v, input logic [7:0] d);
      exp_t e;
      rst = r; in1 = v; in0 = d;
      model_step(r, v, d);
      e.lock = m_lock; e.err = m_err; e.cnt = 8'(m_cnt);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         @(negedge clk);
         checks++;
         if ({out0, out1, out2} !== {e.lock, e.err, e.cnt}) begin
            errors++;
            $display("FAIL scoreboard t=%0t got lock=%b err=%b cnt=%0d want lock=%b err=%b cnt=%0d",
                     $time, out0, out1, out2, e.lock, e.err, e.cnt);
         end
      end
   end

   task automatic test_reset();
      drive(1'b1, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 8'h33);
      checks++;
      if ({out0, out1, out2} !== 10'b0) begin
         errors++;
         $display("FAIL reset got %b/%b/%0d want 0/0/0", out0, out1, out2);
      end
   endtask

   task automatic test_lock();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 8'h10 + 8'(i));
         checks++;
         if (out0 !== (i == 4) || out1 !== 1'b0) begin
            errors++;
            $display("FAIL lock_word%0d got lock=%b err=%b want lock=%b err=0", i, out0, out1, i == 4);
         end
      end
   endtask

   task automatic test_wrap();
      drive(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 8'hF8 + 8'(i));
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 8'hFD + 8'(i));
         checks++;
         if (out0 !== 1'b1 || out1 !== 1'b0 || out2 !== 8'd0) begin
            errors++;
            $display("FAIL wrap_word%0d got %b/%b/%0d want 1/0/0", i, out0, out1, out2);
         end
      end
   endtask

   task automatic test_flywheel();
      drive(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 8'h1B + 8'(i));
      drive(1'b0, 1'b1, 8'h20);
      drive(1'b0, 1'b1, 8'h55);
      checks++;
      if (out1 !== 1'b1 || out2 !== 8'd1 || out0 !== 1'b1) begin
         errors++;
         $display("FAIL flywheel_bad got %b/%b/%0d want 1/1/1", out0, out1, out2);
      end
      drive(1'b0, 1'b1, 8'h22);
      checks++;
      if (out1 !== 1'b0 || out2 !== 8'd1 || out0 !== 1'b1) begin
         errors++;
         $display("FAIL flywheel_resync got %b/%b/%0d want 1/0/1", out0, out1, out2);
      end
   endtask

   task automatic test_unlock();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 8'hAA);
         checks++;
         if (out0 !== (i < 2) || out1 !== 1'b1 || out2 !== 8'(2 + i)) begin
            errors++;
            $display("FAIL unlock_miss%0d got %b/%b/%0d want %b/1/%0d", i, out0, out1, out2, i < 2, 2 + i);
         end
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 8'h40 + 8'(i));
         checks++;
         if (out0 !== (i == 4) || out1 !== 1'b0 || out2 !== 8'd4) begin
            errors++;
            $display("FAIL relock_word%0d got %b/%b/%0d want %b/0/4", i, out0, out1, out2, i == 4);
         end
      end
   endtask

   task automatic test_invalid();
      logic       l0, e0;
      logic [7:0] c0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, 8'h45 + 8'(i));
         l0 = out0; e0 = out1; c0 = out2;
         drive(1'b0, 1'b0, 8'($urandom));
         checks++;
         if (out0 !== l0 || out1 !== 1'b0 || out2 !== c0 || e0 !== 1'b0) begin
            errors++;
            $display("FAIL invalid_gap%0d got %b/%b/%0d want %b/0/%0d", i, out0, out1, out2, l0, c0);
         end
      end
   endtask

   task automatic test_saturate();
      logic [7:0] base;
      base = 8'h4D;  // stream currently expects 0x4D
      for (int r = 0; r < 100; r++) begin
         for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, base + 8'h80);
         base = base + 8'h10;
         for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, base + 8'(i));
         base = base + 8'd5;
      end
      checks++;
      if (out2 !== 8'hFF || out0 !== 1'b1) begin
         errors++;
         $display("FAIL saturate got cnt=%0d lock=%b want cnt=255 lock=1", out2, out0);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 1'b1, 8'h77);
      drive(1'b1, 1'b1, 8'h78);
      checks++;
      if ({out0, out1, out2} !== 10'b0) begin
         errors++;
         $display("FAIL reset_mid got %b/%b/%0d want 0/0/0", out0, out1, out2);
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 8'h79 + 8'(i));
         checks++;
         if (out0 !== (i == 4)) begin
            errors++;
            $display("FAIL post_reset_hunt%0d got lock=%b want %b", i, out0, i == 4);
         end
      end
   endtask

   initial begin
      rst = 1'b1; in1 = 1'b0; in0 = '0;
      test_reset();
      test_lock();
      test_wrap();
      test_flywheel();
      test_unlock();
      test_invalid();
      test_saturate();
      test_reset_mid();
      rst = 1'b0; in1 = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
